// File: rtl/rtc_pkg.sv
// Shared types and helpers for the RTC time-set front panel.
//   set_state_t  : edit FSM state (IDLE, SET_HOUR, SET_MIN, COMMIT)
//   bcd_t        : one BCD digit
//   rtc_time_t   : packed {h10, h1, m10, m1} time value
//   incHoursBcd  : BCD hour increment with 23->00 wrap and invalid->00
//   incMinutesBcd: BCD minute increment with 59->00 wrap and invalid->00
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_COMMIT   = 2'd3
    } set_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h10;
        bcd_t h1;
        bcd_t m10;
        bcd_t m1;
    } rtc_time_t;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

    // With a legal units digit, a plain binary compare against 8'h23 also
    // rejects any tens digit above 2, so it doubles as the range check.
    function automatic logic [7:0] incHoursBcd(input logic [7:0] hours);
        logic [7:0] result;
        logic       valid;
        valid = (hours[3:0] <= 4'd9) && (hours <= HOUR_MAX_BCD);
        if (!valid || (hours == HOUR_MAX_BCD)) begin
            result = 8'h00;
        end else if (hours[3:0] == 4'd9) begin
            result = {hours[7:4] + 4'd1, 4'd0};
        end else begin
            result = {hours[7:4], hours[3:0] + 4'd1};
        end
        return result;
    endfunction

    function automatic logic [7:0] incMinutesBcd(input logic [7:0] minutes);
        logic [7:0] result;
        logic       valid;
        valid = (minutes[3:0] <= 4'd9) && (minutes <= MIN_MAX_BCD);
        if (!valid || (minutes == MIN_MAX_BCD)) begin
            result = 8'h00;
        end else if (minutes[3:0] == 4'd9) begin
            result = {minutes[7:4] + 4'd1, 4'd0};
        end else begin
            result = {minutes[7:4], minutes[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counting debouncer and a
// one-cycle press pulse on each debounced rising edge.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   btn_i   : raw asynchronous button, active-high
//   level_o : debounced button level
//   press_o : 1-cycle pulse per debounced 0->1 transition
// Latency from a clean raw rise to press_o is 2 + DEB_CYC cycles.
module btn_debounce #(
    parameter int DEB_CYC = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // The level only follows the synced input after DEB_CYC consecutive
    // disagreeing samples; a single agreeing sample restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;
    assign press_o = r_press;

endmodule

// File: rtl/rtc_time_set.sv
// RTC front-panel time setter. Two raw buttons (mode, inc) walk an edit
// FSM IDLE -> SET_HOUR -> SET_MIN -> COMMIT -> IDLE over a BCD shadow copy
// of the current time; COMMIT issues a one-cycle load strobe to the RTC.
//   clk_i         : system clock (shared with RTC counters)
//   rst_i         : synchronous active-high reset
//   btn_mode_i    : raw mode button
//   btn_inc_i     : raw increment button
//   time_i        : current RTC time {h10,h1,m10,m1}
//   set_time_o    : edited time (shadow register)
//   set_load_o    : 1-cycle load strobe
//   editing_o     : high in SET_HOUR / SET_MIN
//   digit_blank_o : per-digit blank [3]=h10 [2]=h1 [1]=m10 [0]=m1
// Optional macro RTC_SET_TIMEOUT_EN adds parameter TIMEOUT_S: an edit with
// no button activity for TIMEOUT_S seconds is abandoned without a load.
module rtc_time_set
    import rtc_pkg::*;
#(
    parameter int CLK_HZ      = 10000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int BLINK_HZ    = 2
`ifdef RTC_SET_TIMEOUT_EN
    , parameter int TIMEOUT_S = 10
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_mode_i,
    input  logic        btn_inc_i,
    input  logic [15:0] time_i,
    output logic [15:0] set_time_o,
    output logic        set_load_o,
    output logic        editing_o,
    output logic [3:0]  digit_blank_o
);

    localparam int DEB_RAW    = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEB_CYC    = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int BLINK_RAW  = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_HALF = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
    localparam int BLINK_W    = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF);

    set_state_t         r_state;
    set_state_t         w_nextState;
    rtc_time_t          r_shadow;
    logic               r_editing;
    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_blinkPhase;
    logic               w_modePress;
    logic               w_incPress;
    logic               w_modeLevel;
    logic               w_incLevel;
    logic               w_unusedLevels;
    logic               w_inEdit;
    logic               w_nextInEdit;
    logic               w_editEntry;
    logic               w_incAccepted;
    logic               w_setLoad;
    logic [3:0]         w_blank;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_modeDeb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_mode_i),
        .level_o (w_modeLevel),
        .press_o (w_modePress)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_incDeb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_inc_i),
        .level_o (w_incLevel),
        .press_o (w_incPress)
    );

    // Only the press pulses drive this block; the levels stay available on
    // the debouncer for other users.
    assign w_unusedLevels = w_modeLevel ^ w_incLevel;

    assign w_inEdit      = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN);
    assign w_nextInEdit  = (w_nextState == ST_SET_HOUR) || (w_nextState == ST_SET_MIN);
    assign w_editEntry   = w_nextInEdit && (w_nextState != r_state);
    // Mode wins over a coincident increment.
    assign w_incAccepted = w_incPress && !w_modePress && w_inEdit;

`ifdef RTC_SET_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_S * CLK_HZ;

    logic [31:0] r_toCnt;
    logic        w_timeout;

    assign w_timeout = w_inEdit && !w_modePress && !w_incPress &&
                       (r_toCnt == 32'(TIMEOUT_CYC - 1));

    // Inactivity counter, restarted by any pulse and by any state change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_toCnt <= '0;
        end else if (!w_inEdit || w_modePress || w_incPress || (w_nextState != r_state)) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_editing <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_editing <= w_nextInEdit;
        end
    end

    // Next state plus the outputs decoded from the registered state.
    always_comb begin
        w_nextState = r_state;
        w_setLoad   = 1'b0;
        w_blank     = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (w_modePress) begin
                    w_nextState = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                if (w_modePress) begin
                    w_nextState = ST_SET_MIN;
                end
`ifdef RTC_SET_TIMEOUT_EN
                else if (w_timeout) begin
                    w_nextState = ST_IDLE;
                end
`endif
                if (r_blinkPhase) begin
                    w_blank = 4'b1100;
                end
            end
            ST_SET_MIN: begin
                if (w_modePress) begin
                    w_nextState = ST_COMMIT;
                end
`ifdef RTC_SET_TIMEOUT_EN
                else if (w_timeout) begin
                    w_nextState = ST_IDLE;
                end
`endif
                if (r_blinkPhase) begin
                    w_blank = 4'b0011;
                end
            end
            ST_COMMIT: begin
                w_nextState = ST_IDLE;
                w_setLoad   = 1'b1;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Shadow time: captured on entering an edit, then bumped per field.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
        end else if ((r_state == ST_IDLE) && w_modePress) begin
            r_shadow <= time_i;
        end else if (w_incAccepted) begin
            if (r_state == ST_SET_HOUR) begin
                {r_shadow.h10, r_shadow.h1} <= incHoursBcd({r_shadow.h10, r_shadow.h1});
            end else begin
                {r_shadow.m10, r_shadow.m1} <= incMinutesBcd({r_shadow.m10, r_shadow.m1});
            end
        end
    end

    // Blink timer restarts visible on field entry and after every increment
    // so the user always sees the value they just changed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (w_editEntry || w_incAccepted || !w_inEdit) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (r_blinkCnt == BLINK_W'(BLINK_HALF - 1)) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    assign set_time_o    = r_shadow;
    assign set_load_o    = w_setLoad;
    assign editing_o     = r_editing;
    assign digit_blank_o = w_blank;

endmodule

// File: tb/tb_rtc_time_set.sv
// Self-checking bench for rtc_time_set with CLK_HZ=1000, DEBOUNCE_MS=2
// (DEB_CYC=2) and BLINK_HZ=100 (BLINK_HALF=5). With RTC_SET_TIMEOUT_EN the
// DUT is built with TIMEOUT_S=1 (1000-cycle edit timeout).
module tb_rtc_time_set;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        btn_mode_i = 1'b0;
    logic        btn_inc_i = 1'b0;
    logic [15:0] time_i = 16'h0000;
    logic [15:0] set_time_o;
    logic        set_load_o;
    logic        editing_o;
    logic [3:0]  digit_blank_o;

    int          total = 0;
    int          bad = 0;
    int          loadCount = 0;
    logic [15:0] lastLoad = 16'h0000;

    typedef struct {
        logic [15:0] timeIn;
        logic        doMode;
        logic        doInc;
        logic [15:0] expTime;
        logic        expEdit;
        int          expLoads;
        logic [15:0] expLastLoad;
    } vec_t;

    typedef struct {
        int          row;
        logic [15:0] expTime;
        logic        expEdit;
        int          expLoads;
        logic [15:0] expLastLoad;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[23];

    rtc_time_set #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (2),
        .BLINK_HZ    (100)
`ifdef RTC_SET_TIMEOUT_EN
        , .TIMEOUT_S (1)
`endif
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .btn_mode_i    (btn_mode_i),
        .btn_inc_i     (btn_inc_i),
        .time_i        (time_i),
        .set_time_o    (set_time_o),
        .set_load_o    (set_load_o),
        .editing_o     (editing_o),
        .digit_blank_o (digit_blank_o)
    );

    always #5 clk_i = ~clk_i;

    // Every load strobe cycle is counted, so a strobe longer than one cycle
    // shows up as an extra load.
    always @(negedge clk_i) begin
        if (set_load_o) begin
            loadCount = loadCount + 1;
            lastLoad  = set_time_o;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clean press: 4 cycles high (>= DEB_CYC after sync), then long
    // enough low for the release to settle before the next press.
    task automatic pressButtons(input logic doMode, input logic doInc);
        @(negedge clk_i);
        btn_mode_i = doMode;
        btn_inc_i  = doInc;
        repeat (4) @(negedge clk_i);
        btn_mode_i = 1'b0;
        btn_inc_i  = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic applyStimulus(input int row, input vec_t v);
        exp_t e;
        time_i        = v.timeIn;
        e.row         = row;
        e.expTime     = v.expTime;
        e.expEdit     = v.expEdit;
        e.expLoads    = v.expLoads;
        e.expLastLoad = v.expLastLoad;
        sbQ.push_back(e);
        pressButtons(v.doMode, v.doInc);
    endtask

    task automatic checkOutput();
        exp_t e;
        total = total + 1;
        if (sbQ.size() == 0) begin
            bad = bad + 1;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, want 1");
        end else begin
            total = total - 1;
            e = sbQ.pop_front();
            compareValue($sformatf("row%0d_set_time", e.row), 32'(set_time_o), 32'(e.expTime));
            compareValue($sformatf("row%0d_editing", e.row), 32'(editing_o), 32'(e.expEdit));
            compareValue($sformatf("row%0d_loads", e.row), 32'(loadCount), 32'(e.expLoads));
            compareValue($sformatf("row%0d_last_load", e.row), 32'(lastLoad), 32'(e.expLastLoad));
        end
    endtask

    // Checks n consecutive samples of digit_blank_o, starting at the
    // current negedge, against a 5-visible / 5-blank pattern.
    task automatic checkBlink(input string tag, input int n, input logic [3:0] offMask);
        for (int i = 0; i < n; i++) begin
            compareValue($sformatf("%s[%0d]", tag, i), 32'(digit_blank_o),
                         32'(((i / 5) % 2 == 1) ? offMask : 4'b0000));
            @(negedge clk_i);
        end
    endtask

    initial begin
        int          riseAt;
        logic        sawEdit;
        logic        found;
        int          loadsBefore;
        logic        bouncePat[12];
`ifdef RTC_SET_TIMEOUT_EN
        int          editCycles;
`endif

        vecs[0]  = '{16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 16'h0000};
        vecs[1]  = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b1, 0, 16'h0000};
        vecs[2]  = '{16'h1234, 1'b0, 1'b1, 16'h1334, 1'b1, 0, 16'h0000};
        vecs[3]  = '{16'h1234, 1'b0, 1'b1, 16'h1434, 1'b1, 0, 16'h0000};
        vecs[4]  = '{16'h1234, 1'b1, 1'b0, 16'h1434, 1'b1, 0, 16'h0000};
        vecs[5]  = '{16'h1234, 1'b0, 1'b1, 16'h1435, 1'b1, 0, 16'h0000};
        vecs[6]  = '{16'h1234, 1'b1, 1'b0, 16'h1435, 1'b0, 1, 16'h1435};
        vecs[7]  = '{16'h2359, 1'b1, 1'b0, 16'h2359, 1'b1, 1, 16'h1435};
        vecs[8]  = '{16'h2359, 1'b0, 1'b1, 16'h0059, 1'b1, 1, 16'h1435};
        vecs[9]  = '{16'h2359, 1'b1, 1'b0, 16'h0059, 1'b1, 1, 16'h1435};
        vecs[10] = '{16'h2359, 1'b0, 1'b1, 16'h0000, 1'b1, 1, 16'h1435};
        vecs[11] = '{16'h2359, 1'b1, 1'b0, 16'h0000, 1'b0, 2, 16'h0000};
        vecs[12] = '{16'h0959, 1'b1, 1'b0, 16'h0959, 1'b1, 2, 16'h0000};
        vecs[13] = '{16'h0959, 1'b0, 1'b1, 16'h1059, 1'b1, 2, 16'h0000};
        vecs[14] = '{16'h0959, 1'b1, 1'b1, 16'h1059, 1'b1, 2, 16'h0000};
        vecs[15] = '{16'h0959, 1'b0, 1'b1, 16'h1000, 1'b1, 2, 16'h0000};
        vecs[16] = '{16'h0959, 1'b1, 1'b0, 16'h1000, 1'b0, 3, 16'h1000};
        vecs[17] = '{16'h3561, 1'b1, 1'b0, 16'h3561, 1'b1, 3, 16'h1000};
        vecs[18] = '{16'h3561, 1'b0, 1'b1, 16'h0061, 1'b1, 3, 16'h1000};
        vecs[19] = '{16'h3561, 1'b1, 1'b0, 16'h0061, 1'b1, 3, 16'h1000};
        vecs[20] = '{16'h3561, 1'b0, 1'b1, 16'h0000, 1'b1, 3, 16'h1000};
        vecs[21] = '{16'h3561, 1'b1, 1'b0, 16'h0000, 1'b0, 4, 16'h0000};
        vecs[22] = '{16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 4, 16'h0000};

        bouncePat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        compareValue("reset_set_time", 32'(set_time_o), 32'h0);
        compareValue("reset_editing", 32'(editing_o), 32'h0);
        compareValue("reset_load", 32'(set_load_o), 32'h0);
        compareValue("reset_blank", 32'(digit_blank_o), 32'h0);

        // Glitch and bounce train must not register as a press.
        $display("[TB] debounce glitch/bounce");
        sawEdit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_mode_i = bouncePat[i];
            @(negedge clk_i);
            if (editing_o) sawEdit = 1'b1;
        end
        repeat (6) begin
            @(negedge clk_i);
            if (editing_o) sawEdit = 1'b1;
        end
        compareValue("bounce_no_press", 32'(sawEdit), 32'h0);

        // Stable rise: press at 2+DEB_CYC=4 cycles, editing registered one later.
        btn_mode_i = 1'b1;
        riseAt = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (k == 4) btn_mode_i = 1'b0;
            if (editing_o && (riseAt < 0)) riseAt = k;
        end
        compareValue("stable_press_latency", 32'(riseAt), 32'd5);
        doReset();

        // Table-driven edit flows.
        $display("[TB] edit flow table");
        for (int r = 0; r < 23; r++) begin
            applyStimulus(r, vecs[r]);
            checkOutput();
        end

        // Blink in SET_HOUR from entry.
        $display("[TB] blink checks");
        time_i = 16'h1234;
        @(negedge clk_i);
        btn_mode_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            if (editing_o) found = 1'b1;
        end
        btn_mode_i = 1'b0;
        compareValue("blink_enter_hour", 32'(found), 32'h1);
        checkBlink("blink_hour", 20, 4'b1100);

        // An increment restarts the visible phase.
        btn_inc_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            if (set_time_o != 16'h1234) found = 1'b1;
        end
        btn_inc_i = 1'b0;
        compareValue("blink_inc_hour_time", 32'(set_time_o), 32'h1334);
        checkBlink("blink_hour_after_inc", 10, 4'b1100);

        // Move to SET_MIN, then align on an increment there.
        pressButtons(1'b1, 1'b0);
        btn_inc_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            if (set_time_o != 16'h1334) found = 1'b1;
        end
        btn_inc_i = 1'b0;
        compareValue("blink_inc_min_time", 32'(set_time_o), 32'h1335);
        checkBlink("blink_min", 10, 4'b0011);

        // Reset in SET_MIN abandons the edit without a load.
        loadsBefore = loadCount;
        rst_i = 1'b1;
        @(negedge clk_i);
        compareValue("midreset_set_time", 32'(set_time_o), 32'h0);
        compareValue("midreset_editing", 32'(editing_o), 32'h0);
        compareValue("midreset_load", 32'(set_load_o), 32'h0);
        compareValue("midreset_blank", 32'(digit_blank_o), 32'h0);
        rst_i = 1'b0;
        repeat (12) @(negedge clk_i);
        compareValue("midreset_no_load", 32'(loadCount), 32'(loadsBefore));
        compareValue("midreset_idle", 32'(editing_o), 32'h0);

`ifdef RTC_SET_TIMEOUT_EN
        // Edit timeout: 1000 idle cycles in SET_HOUR, then IDLE without load.
        $display("[TB] edit timeout");
        time_i = 16'h0815;
        loadsBefore = loadCount;
        @(negedge clk_i);
        btn_mode_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            if (editing_o) found = 1'b1;
        end
        btn_mode_i = 1'b0;
        compareValue("timeout_enter", 32'(found), 32'h1);
        editCycles = 0;
        for (int k = 0; k < 1500 && editing_o; k++) begin
            editCycles = editCycles + 1;
            @(negedge clk_i);
        end
        compareValue("timeout_cycles", 32'(editCycles), 32'd1000);
        compareValue("timeout_no_load", 32'(loadCount), 32'(loadsBefore));
        compareValue("timeout_shadow_kept", 32'(set_time_o), 32'h0815);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_time_set.md
Name: rtc_time_set

Overview:
- User-input end of the RTC front panel: turns two raw push-buttons into a BCD HH:MM value and a one-cycle load strobe that the RTC counter chain consumes.
- The display path is the reader of the time; this block is the writer.
- It supplies per-digit blank flags so the display blinks the field being edited.
- It sits between board buttons and the RTC counters, and shares clk_i with them.

Parameters:
- CLK_HZ, 10000000, clk_i frequency in Hz.
- DEBOUNCE_MS, 20, button stable time. Local DEB_CYC = (CLK_HZ/1000)*DEBOUNCE_MS, minimum 1.
- BLINK_HZ, 2, edit-field blink rate. Local BLINK_HALF = CLK_HZ/(2*BLINK_HZ).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- btn_mode_i  in  1  raw mode button, asynchronous, active-high.
- btn_inc_i  in  1  raw increment button, asynchronous, active-high.
- time_i  in  16  current RTC time {h10,h1,m10,m1}, 4 bits BCD each.
- set_time_o  out  16  edited time {h10,h1,m10,m1}.
- set_load_o  out  1  one-cycle strobe; the RTC loads set_time_o and clears seconds to 0.
- editing_o  out  1  high while in SET_HOUR or SET_MIN.
- digit_blank_o  out  4  per-digit blank: [3]=h10, [2]=h1, [1]=m10, [0]=m1.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shadow register 0, debouncers at level 0, blink and timeout counters 0. Reset taken mid-edit returns to IDLE with no load strobe.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounced level flips only after the synced input differs from it for DEB_CYC consecutive cycles; any agreeing sample clears the count.
  - One press pulse of 1 cycle per debounced 0->1 transition; release produces no pulse.
  - Latency from a clean raw rise to the pulse: 2 + DEB_CYC cycles.
- FSM states: IDLE, SET_HOUR, SET_MIN, COMMIT.
  - IDLE + mode pulse: shadow <= time_i, go to SET_HOUR.
  - SET_HOUR + mode pulse: go to SET_MIN.
  - SET_MIN + mode pulse: go to COMMIT.
  - COMMIT lasts exactly 1 cycle with set_load_o=1, then IDLE.
- Increment pulse in SET_HOUR: hours BCD +1.
  - 23 -> 00.
  - Any captured invalid hour (not a BCD value < 24) -> 00.
  - h1 9 -> 0 carries into h10.
- Increment pulse in SET_MIN: minutes BCD +1.
  - 59 -> 00.
  - Invalid value -> 00.
  - Hours unaffected.
- Increment pulse in IDLE or COMMIT: ignored.
- Mode and inc pulses in the same cycle: mode wins, inc is dropped.
- set_time_o = shadow register at all times. It only changes on capture or increment, and is stable during COMMIT.
- Blink:
  - Counter restarts at 0 on entry to SET_HOUR/SET_MIN and on every inc pulse, so the field is visible first.
  - Phase toggles every BLINK_HALF cycles.
  - SET_HOUR off-phase: digit_blank_o=4'b1100. SET_MIN off-phase: 4'b0011.
  - Otherwise 4'b0000, including IDLE.
- editing_o is registered and aligned with the state register.

Optional Feature:
- Macro: RTC_SET_TIMEOUT_EN.
- Defined: parameter TIMEOUT_S (default 10). If no mode or inc pulse occurs for TIMEOUT_S*CLK_HZ cycles while in SET_HOUR/SET_MIN, the FSM returns to IDLE with no set_load_o; the shadow is retained but unused. The counter clears on every pulse and on state entry.
- Undefined: no timeout logic; editing persists indefinitely.

Decomposition:
- Package rtc_pkg holds:
  - FSM state enum (2 bits).
  - BCD digit typedef (4 bits).
  - Packed time typedef {h10,h1,m10,m1}.
  - Constants HOUR_MAX_BCD=8'h23, MIN_MAX_BCD=8'h59.
- Sub-module btn_debounce (param DEB_CYC; ports clk_i, rst_i, btn_i, level_o, press_o), instantiated twice.

Test Plan (CLK_HZ=1000, DEBOUNCE_MS=2 → DEB_CYC=2; BLINK_HZ=100 → BLINK_HALF=5):
- Raw mode pulse of 1 cycle, then a bounce train 1,0,1 -> no press pulse. Stable high for 4 cycles -> exactly one press pulse at cycle 2+DEB_CYC after the stable rise.
- Full edit flow:
  - time_i=16'h1234 (h10=1, h1=2, m10=3, m1=4); sequence mode, inc×2, mode, inc, mode.
  - Result: one cycle of set_load_o=1 with set_time_o=16'h1435; then IDLE with editing_o=0.
- Wrap checks:
  - Capture 16'h2359; inc in SET_HOUR -> 16'h0059; inc in SET_MIN -> 16'h0000.
  - Capture 16'h0959; inc in SET_HOUR -> 16'h1059.
- Same-cycle mode+inc pulses in SET_HOUR -> move to SET_MIN with hours unchanged.
- Blink: in SET_HOUR, digit_blank_o = 0000 for 5 cycles, then 1100 for 5 cycles, repeating. An inc pulse restarts the 0000 phase.
- Reset during SET_MIN -> next cycle all outputs 0, no set_load_o. With RTC_SET_TIMEOUT_EN and TIMEOUT_S=1: 1000 idle cycles in SET_HOUR -> IDLE, no load.
